// File: rtl/biu_arb_pkg.sv
// Shared definitions for the bus-interface arbiter: FSM state encoding,
// fault-bit positions and the latched bus command record.
package biu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_IF_DROP  = 2'd3
    } arb_state_e;

    // Bit positions inside the {page_fault, acc_fault} pair
    localparam int unsigned FAULT_ACC_BIT  = 0;
    localparam int unsigned FAULT_PAGE_BIT = 1;

    // Everything presented on the bus for one transaction
    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [3:0]  priv;
    } bus_cmd_t;

    // A fetch is always a read with no data and a zero size code
    function automatic bus_cmd_t if_cmd(input logic [63:0] addr, input logic [3:0] priv);
        bus_cmd_t cmd;
        cmd.wr    = 1'b0;
        cmd.addr  = addr;
        cmd.wdata = 64'd0;
        cmd.size  = 4'd0;
        cmd.priv  = priv;
        return cmd;
    endfunction

endpackage

// File: rtl/biu_arb_pick.sv
// Arbitration priority: MEM normally wins, IF wins when it has been starved
// for the maximum number of MEM grants. A fetch that is being flushed in the
// same cycle is never granted.
module biu_arb_pick (
    input  logic idle,
    input  logic if_rd,
    input  logic pip_flush,
    input  logic mem_req,
    input  logic starve_full,
    output logic grant_if,
    output logic grant_mem
);

    logic if_ok_s;

    // Decide which requester (if any) receives the bus this cycle
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if_ok_s   = if_rd & ~pip_flush;
        if (idle) begin
            if (if_ok_s && (!mem_req || starve_full)) begin
                grant_if = 1'b1;
            end else if (mem_req) begin
                grant_mem = 1'b1;
            end else begin
                grant_if  = 1'b0;
                grant_mem = 1'b0;
            end
        end else begin
            grant_if  = 1'b0;
            grant_mem = 1'b0;
        end
    end

endmodule

// File: rtl/biu_arb.sv
// Two-master (instruction fetch / data memory) arbiter in front of a single
// L1/BIU port. One outstanding bus transaction at a time; the request is
// registered at grant and held until the bus returns bus_ready.
module biu_arb
    import biu_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pip_flush,
    input  logic        if_rd,
    input  logic [63:0] if_addr,
    input  logic [3:0]  if_priv,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [3:0]  mem_size,
    input  logic [3:0]  mem_priv,
    output logic        mem_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_fault,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [3:0]  bus_size,
    output logic [3:0]  bus_priv,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ready,
    input  logic [1:0]  bus_fault
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    bus_cmd_t      cmd_q, cmd_d;
    logic          bus_req_q, bus_req_d;
    logic          if_ready_s, mem_ready_s;
    logic          grant_if_s, grant_mem_s;

    biu_arb_pick u_pick (
        .idle        (state_q == ST_IDLE),
        .if_rd       (if_rd),
        .pip_flush   (pip_flush),
        .mem_req     (mem_req),
        .starve_full (starve_q == STARVE_LIM),
        .grant_if    (grant_if_s),
        .grant_mem   (grant_mem_s)
    );

    // Next-state, command latch, starvation counter and completion pulses
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cmd_d       = cmd_q;
        bus_req_d   = bus_req_q;
        if_ready_s  = 1'b0;
        mem_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // bus_ready arriving here belongs to nobody and is ignored
                if (grant_if_s) begin
                    state_d   = ST_IF_BUSY;
                    cmd_d     = if_cmd(if_addr, if_priv);
                    bus_req_d = 1'b1;
                    starve_d  = {CW{1'b0}};
                end else if (grant_mem_s) begin
                    state_d     = ST_MEM_BUSY;
                    cmd_d.wr    = mem_wr;
                    cmd_d.addr  = mem_addr;
                    cmd_d.wdata = mem_wdata;
                    cmd_d.size  = mem_size;
                    cmd_d.priv  = mem_priv;
                    bus_req_d   = 1'b1;
                    if (!if_rd) begin
                        starve_d = {CW{1'b0}};
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + CW'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (!if_rd) begin
                    starve_d = {CW{1'b0}};
                end else begin
                    starve_d = starve_q;
                end
            end
            ST_IF_BUSY: begin
                if (bus_ready) begin
                    // A flush landing with the data still kills the response
                    state_d    = ST_IDLE;
                    bus_req_d  = 1'b0;
                    if_ready_s = ~pip_flush;
                end else if (pip_flush) begin
                    state_d = ST_IF_DROP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_MEM_BUSY: begin
                if (bus_ready) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    mem_ready_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_IF_DROP: begin
                // Drain the abandoned fetch silently
                if (bus_ready) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and bus command registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            starve_q  <= {CW{1'b0}};
            cmd_q     <= '0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            cmd_q     <= cmd_d;
            bus_req_q <= bus_req_d;
        end
    end

    // Completion pulses are qualified so that reset never lets one escape
    assign if_ready  = if_ready_s & ~rst;
    assign mem_ready = mem_ready_s & ~rst;

    assign rsp_data  = bus_rdata;
    assign rsp_fault = {bus_fault[FAULT_PAGE_BIT], bus_fault[FAULT_ACC_BIT]};

    assign bus_req   = bus_req_q;
    assign bus_wr    = cmd_q.wr;
    assign bus_addr  = cmd_q.addr;
    assign bus_wdata = cmd_q.wdata;
    assign bus_size  = cmd_q.size;
    assign bus_priv  = cmd_q.priv;

endmodule

// File: tb/tb_biu_arb.sv
// Scoreboard bench for biu_arb: stimulus drives inputs on the falling edge
// and a transaction-level model pushes expected grants/responses into queues;
// a separate monitor pops and compares what the DUT presents.
module tb_biu_arb;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pip_flush = 1'b0;
    logic        if_rd = 1'b0;
    logic [63:0] if_addr = 64'd0;
    logic [3:0]  if_priv = 4'd0;
    logic        if_ready;
    logic        mem_req = 1'b0;
    logic        mem_wr = 1'b0;
    logic [63:0] mem_addr = 64'd0;
    logic [63:0] mem_wdata = 64'd0;
    logic [3:0]  mem_size = 4'd0;
    logic [3:0]  mem_priv = 4'd0;
    logic        mem_ready;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        bus_req, bus_wr;
    logic [63:0] bus_addr, bus_wdata;
    logic [3:0]  bus_size, bus_priv;
    logic [63:0] bus_rdata = 64'd0;
    logic        bus_ready = 1'b0;
    logic [1:0]  bus_fault = 2'b00;

    always #5 clk = ~clk;

    biu_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .pip_flush(pip_flush),
        .if_rd(if_rd), .if_addr(if_addr), .if_priv(if_priv), .if_ready(if_ready),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_priv(mem_priv), .mem_ready(mem_ready),
        .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_size(bus_size), .bus_priv(bus_priv),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_fault(bus_fault)
    );

    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [3:0]  priv;
    } grant_t;

    typedef struct packed {
        logic        is_if;
        logic [63:0] data;
        logic [1:0]  fault;
    } rsp_t;

    grant_t grant_q[$];
    rsp_t   rsp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: one outstanding transaction, who owns it, whether it was flushed
    bit m_busy = 1'b0, m_src_if = 1'b0, m_dropped = 1'b0, m_rst_prev = 1'b1;
    int m_starve = 0;
    bit m_granted, m_if_done, m_mem_done;

    // Values the monitor compares against this cycle
    bit mon_en = 1'b0, exp_bus_req = 1'b0, chk_rst = 1'b0;

    // Directed-test field values
    logic [63:0] d_if_addr = 64'd0, d_mem_addr = 64'd0, d_mem_wdata = 64'd0;
    logic [3:0]  d_if_priv = 4'd0, d_mem_size = 4'd0, d_mem_priv = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        grant_t g;
        exp_bus_req = m_busy;
        chk_rst     = m_rst_prev;
        m_rst_prev  = rst;
        m_granted   = 1'b0;
        m_if_done   = 1'b0;
        m_mem_done  = 1'b0;
        if (rst) begin
            m_busy   = 1'b0;
            m_starve = 0;
        end else if (!m_busy) begin
            if (if_rd && !pip_flush && (!mem_req || m_starve == STARVE_MAX)) begin
                g = '{wr: 1'b0, addr: if_addr, wdata: 64'd0, size: 4'd0, priv: if_priv};
                grant_q.push_back(g);
                m_busy = 1'b1; m_src_if = 1'b1; m_dropped = 1'b0; m_granted = 1'b1;
                m_starve = 0;
            end else if (mem_req) begin
                g = '{wr: mem_wr, addr: mem_addr, wdata: mem_wdata, size: mem_size, priv: mem_priv};
                grant_q.push_back(g);
                m_busy = 1'b1; m_src_if = 1'b0; m_dropped = 1'b0; m_granted = 1'b1;
                if (if_rd) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
                else       m_starve = 0;
            end else if (!if_rd) begin
                m_starve = 0;
            end
        end else if (bus_ready) begin
            if (!m_src_if) begin
                rsp_q.push_back('{is_if: 1'b0, data: bus_rdata, fault: bus_fault});
                m_mem_done = 1'b1;
            end else if (!m_dropped && !pip_flush) begin
                rsp_q.push_back('{is_if: 1'b1, data: bus_rdata, fault: bus_fault});
                m_if_done = 1'b1;
            end
            m_busy = 1'b0;
        end else if (m_src_if && pip_flush) begin
            m_dropped = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit fl, input bit ird, input logic [63:0] ia,
                        input logic [3:0] ip, input bit mrq, input bit mw, input logic [63:0] ma,
                        input logic [63:0] md, input logic [3:0] ms, input logic [3:0] mp,
                        input bit br, input logic [63:0] rd, input logic [1:0] bf);
        @(negedge clk);
        rst = r; pip_flush = fl;
        if_rd = ird; if_addr = ia; if_priv = ip;
        mem_req = mrq; mem_wr = mw; mem_addr = ma; mem_wdata = md; mem_size = ms; mem_priv = mp;
        bus_ready = br; bus_rdata = rd; bus_fault = bf;
        model_step();
        mon_en = 1'b1;
    endtask

    task automatic dir(input bit r, input bit fl, input bit ird, input bit mrq, input bit mw,
                       input bit br, input logic [63:0] rd, input logic [1:0] bf);
        step(r, fl, ird, d_if_addr, d_if_priv, mrq, mw, d_mem_addr, d_mem_wdata,
             d_mem_size, d_mem_priv, br, rd, bf);
    endtask

    // Monitor: compares DUT outputs against the queued expectations each cycle
    bit     prev_bus_req = 1'b0;
    bit     cur_valid = 1'b0;
    grant_t cur;
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            chk("ready_exclusive", 64'(if_ready & mem_ready), 64'd0);
            chk("bus_req", 64'(bus_req), 64'(exp_bus_req));
            if (chk_rst) begin
                chk("rst_bus_wr", 64'(bus_wr), 64'd0);
                chk("rst_bus_addr", bus_addr, 64'd0);
                chk("rst_bus_wdata", bus_wdata, 64'd0);
                chk("rst_bus_size_priv", 64'({bus_size, bus_priv}), 64'd0);
            end
            if (bus_req && !prev_bus_req) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", 64'd1, 64'd0);
                end else begin
                    cur = grant_q.pop_front();
                    cur_valid = 1'b1;
                    chk("grant_wr", 64'(bus_wr), 64'(cur.wr));
                    chk("grant_addr", bus_addr, cur.addr);
                    chk("grant_wdata", bus_wdata, cur.wdata);
                    chk("grant_size", 64'(bus_size), 64'(cur.size));
                    chk("grant_priv", 64'(bus_priv), 64'(cur.priv));
                end
            end else if (bus_req && cur_valid) begin
                chk("hold_addr", bus_addr, cur.addr);
                chk("hold_wdata_wr", 64'({bus_wdata[62:0], bus_wr}), 64'({cur.wdata[62:0], cur.wr}));
            end
            prev_bus_req = bus_req;
            if (rsp_q.size() != 0) begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("if_ready", 64'(if_ready), 64'(e.is_if));
                chk("mem_ready", 64'(mem_ready), 64'(!e.is_if));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
            end else begin
                chk("no_if_ready", 64'(if_ready), 64'd0);
                chk("no_mem_ready", 64'(mem_ready), 64'd0);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    bit          if_pend = 1'b0, mem_pend = 1'b0;
    logic [63:0] r_if_addr = 64'd0, r_mem_addr = 64'd0, r_mem_wdata = 64'd0;
    logic [3:0]  r_if_priv = 4'd0, r_mem_size = 4'd0, r_mem_priv = 4'd0;
    bit          r_mem_wr = 1'b0;
    int          wait_cnt = 0;
    initial begin
        dir(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 2'b11);   // stray bus_ready in IDLE

        // Single fetch, bus_ready three cycles after the grant edge
        d_if_addr = 64'h1000; d_if_priv = 4'h3;
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hDEAD, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);

        // Simultaneous fetch and store: store first
        d_mem_addr = 64'h2000; d_mem_wdata = 64'hCAFE_F00D; d_mem_size = 4'h3; d_mem_priv = 4'h1;
        dir(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h11, 2'b00);
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1234, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);

        // Starvation: MEM held with IF waiting; IF wins after STARVE_MAX grants
        for (int i = 0; i < STARVE_MAX + 2; i++) begin
            dir(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00);
            dir(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'(i + 100), 2'b00);
        end
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);

        // Flush during IF_BUSY, data two cycles later, then a new request
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hBEEF, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h42, 2'b10);
        // Flush coincident with bus_ready, and flush with if_rd in IDLE
        dir(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h99, 2'b00);
        dir(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);

        // Reset in MEM_BUSY with bus_ready, then a faulting load
        dir(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 2'b00);
        dir(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h5, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00);
        dir(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h55, 2'b01);
        dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit          r, fl, br;
            logic [63:0] rd;
            logic [1:0]  bf;
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 11) == 0);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1; r_if_addr = {$urandom, $urandom}; r_if_priv = 4'($urandom);
            end
            if (!mem_pend && $urandom_range(0, 1) == 0) begin
                mem_pend = 1'b1; r_mem_wr = 1'($urandom);
                r_mem_addr = {$urandom, $urandom}; r_mem_wdata = {$urandom, $urandom};
                r_mem_size = 4'($urandom); r_mem_priv = 4'($urandom);
            end
            br = 1'b0;
            if (m_busy) begin
                if (wait_cnt == 0) br = 1'b1;
                else wait_cnt--;
            end else begin
                br = ($urandom_range(0, 5) == 0);
            end
            rd = {$urandom, $urandom};
            bf = 2'($urandom);
            step(r, fl, if_pend, r_if_addr, r_if_priv, mem_pend, r_mem_wr, r_mem_addr,
                 r_mem_wdata, r_mem_size, r_mem_priv, br, rd, bf);
            if (m_granted) wait_cnt = $urandom_range(0, 3);
            if (r || fl || m_if_done) if_pend = 1'b0;
            if (r || m_mem_done) mem_pend = 1'b0;
        end

        // Drain any outstanding transaction
        for (int i = 0; i < 4; i++) begin
            dir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_busy, 64'hA5, 2'b00);
        end
        @(negedge clk);
        #4;
        chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
